// File: rtl/bank_lfu_ctrl.sv
// Per-bank linefill unit: allocates slots, arbitrates BIU reads, tracks beats.
// Optional LFU_TIMEOUT_EN adds per-slot data watchdog counters.
module bank_lfu_ctrl #(
  parameter int         SLOT_NUM = 8,
  parameter int         BEAT_NUM = 4,
  parameter logic [2:0] BANK_ID  = 3'd0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lf_req_valid_i,
  output logic        lf_req_ready_o,
  input  logic [31:0] lf_req_addr_i,
  output logic [5:0]  lf_req_id_o,
  output logic        biu_ar_valid_o,
  input  logic        biu_ar_ready_i,
  output logic [31:0] biu_ar_addr_o,
  output logic [5:0]  biu_ar_id_o,
  input  logic        biu_r_valid_i,
  input  logic [5:0]  biu_r_id_i,
  input  logic        biu_r_last_i,
  output logic        lf_done_valid_o,
  output logic [5:0]  lf_done_id_o,
  output logic        lf_err_o,
  output logic        lf_timeout_o,
  output logic [3:0]  lf_busy_cnt_o
);

  localparam int SW = (SLOT_NUM > 1) ? $clog2(SLOT_NUM) : 1;
  localparam int CW = (BEAT_NUM > 1) ? $clog2(BEAT_NUM) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BEAT_NUM - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_AR,
    S_WAIT_DATA,
    S_DONE
  } slot_st_e;

  slot_st_e      st_q   [SLOT_NUM];
  slot_st_e      st_d   [SLOT_NUM];
  logic [31:0]   addr_q [SLOT_NUM];
  logic [CW-1:0] beat_q [SLOT_NUM];
  logic [CW-1:0] beat_d [SLOT_NUM];

  logic [SW-1:0] rr_q, rr_d;
  logic          lock_q, lock_d;
  logic [SW-1:0] lock_slot_q, lock_slot_d;
  logic          done_q, done_d;
  logic [5:0]    done_id_q, done_id_d;
  logic          err_q, err_d;

  logic          alloc_hit;
  logic [SW-1:0] alloc_idx;
  logic          accept;
  logic          arb_hit;
  logic [SW-1:0] arb_idx;
  logic [SW-1:0] ar_sel;
  logic          ar_hs;
  logic [SW-1:0] r_idx;
  logic          r_acc;
  logic          r_at_end;
  logic          r_fin;
  logic          r_inc;
  logic          r_bad;
  logic [3:0]    busy_cnt;

  // Lowest-index idle slot is the allocation target.
  always_comb begin
    alloc_hit = 1'b0;
    alloc_idx = '0;
    for (int i = SLOT_NUM - 1; i >= 0; i--) begin
      if (st_q[i] == S_IDLE) begin
        alloc_hit = 1'b1;
        alloc_idx = SW'(i);
      end
    end
  end

  assign accept         = lf_req_valid_i & alloc_hit;
  assign lf_req_ready_o = alloc_hit;
  assign lf_req_id_o    = {BANK_ID, 3'(alloc_idx)};

  // Round-robin search over WAIT_AR slots starting at the pointer.
  always_comb begin
    logic [SW-1:0] idx;
    arb_hit = 1'b0;
    arb_idx = rr_q;
    idx     = '0;
    for (int k = SLOT_NUM - 1; k >= 0; k--) begin
      idx = rr_q + SW'(k);
      if (st_q[idx] == S_WAIT_AR) begin
        arb_hit = 1'b1;
        arb_idx = idx;
      end
    end
  end

  // A stalled grant is frozen so addr/id cannot change under valid.
  assign ar_sel         = lock_q ? lock_slot_q : arb_idx;
  assign biu_ar_valid_o = arb_hit;
  assign biu_ar_addr_o  = addr_q[ar_sel];
  assign biu_ar_id_o    = {BANK_ID, 3'(ar_sel)};
  assign ar_hs          = arb_hit & biu_ar_ready_i;

  assign lock_d      = arb_hit & ~biu_ar_ready_i;
  assign lock_slot_d = ar_sel;
  assign rr_d        = ar_hs ? ar_sel + SW'(1) : rr_q;

  // Read beat qualification and protocol error detection.
  always_comb begin
    logic bank_ok;
    logic slot_ok;
    bank_ok  = biu_r_id_i[5:3] == BANK_ID;
    slot_ok  = {29'd0, biu_r_id_i[2:0]} < 32'(SLOT_NUM);
    r_idx    = biu_r_id_i[SW-1:0];
    r_acc    = bank_ok & slot_ok & (st_q[r_idx] == S_WAIT_DATA);
    r_at_end = beat_q[r_idx] == LAST_CNT;
    r_fin    = biu_r_valid_i & r_acc & biu_r_last_i & r_at_end;
    r_inc    = biu_r_valid_i & r_acc & ~biu_r_last_i & ~r_at_end;
    r_bad    = biu_r_valid_i &
               (~r_acc | (biu_r_last_i != r_at_end));
  end

  assign done_d    = r_fin;
  assign done_id_d = {BANK_ID, biu_r_id_i[2:0]};
  assign err_d     = r_bad;

  // Per-slot next state and beat counter.
  always_comb begin
    for (int i = 0; i < SLOT_NUM; i++) begin
      st_d[i]   = st_q[i];
      beat_d[i] = beat_q[i];
      unique case (st_q[i])
        S_IDLE: begin
          if (accept && alloc_idx == SW'(i))
            st_d[i] = S_WAIT_AR;
        end
        S_WAIT_AR: begin
          if (ar_hs && ar_sel == SW'(i)) begin
            st_d[i]   = S_WAIT_DATA;
            beat_d[i] = '0;
          end
        end
        S_WAIT_DATA: begin
          if (r_idx == SW'(i) && r_inc)
            beat_d[i] = beat_q[i] + CW'(1);
          if (r_idx == SW'(i) && r_fin)
            st_d[i] = S_DONE;
        end
        S_DONE: begin
          st_d[i] = S_IDLE;
        end
        default: begin
          st_d[i] = S_IDLE;
        end
      endcase
    end
  end

  // Slot state, beat counters and captured addresses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < SLOT_NUM; i++) begin
        st_q[i]   <= S_IDLE;
        beat_q[i] <= '0;
        addr_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SLOT_NUM; i++) begin
        st_q[i]   <= st_d[i];
        beat_q[i] <= beat_d[i];
        if (accept && alloc_idx == SW'(i))
          addr_q[i] <= lf_req_addr_i;
      end
    end
  end

  // Arbiter pointer, grant lock and registered status pulses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q        <= '0;
      lock_q      <= 1'b0;
      lock_slot_q <= '0;
      done_q      <= 1'b0;
      done_id_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      lock_q      <= lock_d;
      lock_slot_q <= lock_slot_d;
      done_q      <= done_d;
      done_id_q   <= done_id_d;
      err_q       <= err_d;
    end
  end

  assign lf_done_valid_o = done_q;
  assign lf_done_id_o    = done_id_q;
  assign lf_err_o        = err_q;

  // Occupancy is a population count, so it cannot exceed SLOT_NUM.
  always_comb begin
    busy_cnt = '0;
    for (int i = 0; i < SLOT_NUM; i++) begin
      if (st_q[i] != S_IDLE)
        busy_cnt = busy_cnt + 4'd1;
    end
  end

  assign lf_busy_cnt_o = busy_cnt;

`ifdef LFU_TIMEOUT_EN
  logic [9:0] tmo_q [SLOT_NUM];
  logic       timeout_q;

  // Data watchdog: saturating per-slot counters, sticky flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < SLOT_NUM; i++)
        tmo_q[i] <= '0;
      timeout_q <= 1'b0;
    end else begin
      for (int i = 0; i < SLOT_NUM; i++) begin
        if (ar_hs && ar_sel == SW'(i))
          tmo_q[i] <= '0;
        else if (st_q[i] == S_WAIT_DATA && tmo_q[i] != 10'h3FF)
          tmo_q[i] <= tmo_q[i] + 10'd1;
        if (st_q[i] == S_WAIT_DATA && tmo_q[i] == 10'h3FF)
          timeout_q <= 1'b1;
      end
    end
  end

  assign lf_timeout_o = timeout_q;
`else
  assign lf_timeout_o = 1'b0;
`endif

endmodule

// File: doc/bank_lfu_ctrl.md
BANK_LFU_CTRL -- requirements
Module: bank_lfu_ctrl

Interface
REQ-001 SHALL have parameters: SLOT_NUM, default 8, number of outstanding linefill slots (power of 2).
REQ-002 SHALL have parameters: BEAT_NUM, default 4, BIU read beats per cacheline.
REQ-003 SHALL have parameters: BANK_ID, default 0, 3-bit bank tag placed in the upper bits of the BIU id.
REQ-004 SHALL have ports as follows.
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- lf_req_valid_i  in  1  linefill request from issue stage
- lf_req_ready_o  out  1  a free slot exists
- lf_req_addr_i  in  32  cacheline-aligned address
- lf_req_id_o  out  6  BIU id assigned to the accepted request, combinational, valid with lf_req_ready_o
- biu_ar_valid_o  out  1  read address valid
- biu_ar_ready_i  in  1  read address ready
- biu_ar_addr_o  out  32  read address
- biu_ar_id_o  out  6  read id = {BANK_ID, slot}
- biu_r_valid_i  in  1  read data beat valid
- biu_r_id_i  in  6  read data id
- biu_r_last_i  in  1  last beat
- lf_done_valid_o  out  1  one-cycle pulse, linefill complete
- lf_done_id_o  out  6  id of completed linefill
- lf_err_o  out  1  one-cycle pulse, protocol error
- lf_timeout_o  out  1  sticky watchdog flag
- lf_busy_cnt_o  out  4  number of non-IDLE slots

Function
REQ-005 Each slot SHALL run an FSM: IDLE -> WAIT_AR on accept; WAIT_AR -> WAIT_DATA on AR handshake; WAIT_DATA -> DONE on accepted last beat; DONE -> IDLE after exactly one cycle.
REQ-006 lf_req_ready_o SHALL be 1 iff any slot is IDLE; accept = lf_req_valid_i & lf_req_ready_o.
REQ-007 Allocation SHALL pick the lowest-index IDLE slot; lf_req_id_o = {BANK_ID, that slot}; the address is latched into the slot on accept.
REQ-008 A slot in DONE SHALL NOT be allocatable in the same cycle; it becomes allocatable the next cycle.
REQ-009 AR arbitration SHALL be round-robin over WAIT_AR slots, starting from the slot after the last granted slot; the pointer SHALL reset to slot 0 and advance only on a handshake.
REQ-010 biu_ar_valid_o SHALL be 1 iff any slot is WAIT_AR; the addr and id SHALL remain stable while valid & ~ready.
REQ-011 A newly accepted request SHALL NOT drive biu_ar_valid_o before the next cycle, so the minimum accept-to-AR latency is 1 cycle.
REQ-012 Each WAIT_DATA slot SHALL keep a beat counter of width clog2(BEAT_NUM); the counter SHALL clear on AR handshake and increment on each matching beat.
REQ-013 A beat is accepted when biu_r_valid_i is set, the upper 3 bits of the id equal BANK_ID, and the addressed slot is in WAIT_DATA.
REQ-014 When biu_r_last_i is set and the counter equals BEAT_NUM-1, the slot SHALL move to DONE.
REQ-015 lf_err_o SHALL pulse, with no state change, on any of: a beat with a foreign BANK_ID; a beat to a slot not in WAIT_DATA; biu_r_last_i with counter != BEAT_NUM-1; the counter reaching BEAT_NUM-1 without last.
REQ-016 lf_done_valid_o/lf_done_id_o SHALL be registered and asserted in the cycle the slot is in DONE; at most one done per cycle.
REQ-017 An AR handshake and an R beat in the same cycle for different slots SHALL both be processed.
REQ-018 Accepting a request and retiring a slot from DONE in the same cycle SHALL leave lf_busy_cnt_o unchanged.
REQ-019 lf_busy_cnt_o SHALL saturate only at SLOT_NUM and never wrap.

Reset
REQ-020 On rst_i all slots SHALL go to IDLE, counters and RR pointer to 0, and registered outputs to 0; lf_req_ready_o becomes 1.
REQ-021 Reset mid-operation SHALL discard all outstanding linefills without issuing done pulses; late R beats after reset SHALL raise lf_err_o.

Configuration
REQ-022 With LFU_TIMEOUT_EN defined, each WAIT_DATA slot SHALL run a 10-bit cycle counter cleared on AR handshake; reaching 1023 sets lf_timeout_o sticky until reset, and the slot state is unchanged.
REQ-023 Without LFU_TIMEOUT_EN, the counters SHALL be absent and lf_timeout_o SHALL be tied 0.

Verification
REQ-024 Single linefill, BANK_ID=2, ar_ready=1: req addr 0x1000 -> id 0x10; AR in cycle +1; four beats with last on the 4th -> done pulse with id 0x10 one cycle after the last beat.
REQ-025 Eight back-to-back requests -> ids 0x10..0x17, ready drops after the 8th; after one slot completes, ready returns one cycle after its done pulse.
REQ-026 Hold ar_ready=0 for 5 cycles with slots 0, 1, 2 in WAIT_AR -> AR addr/id stable; grants follow in order 0, 1, 2, then wrap correctly on the next round.
REQ-027 Interleave beats for slots 1 and 3; send last on the 3rd beat to slot 3 -> lf_err_o pulses, slot 3 stays in WAIT_DATA, and slot 1 completes normally.
REQ-028 Beat with id 0x38 (foreign bank) -> lf_err_o pulses and no state change; assert rst_i with 3 slots busy -> busy_cnt=0, no done pulse.
REQ-029 With LFU_TIMEOUT_EN defined, AR handshake then no data for 1023 cycles -> lf_timeout_o=1 and it stays set; without the macro, lf_timeout_o stays 0.
